// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback,
// with a registered write stage, busy scoreboard and conflict counter. Optional macro: WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_addr,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0]      rd_a1,
    input  logic [ADDR_W-1:0]      rd_a2,
    input  logic [DATA_W-1:0]      rf_rd1,
    input  logic [DATA_W-1:0]      rf_rd2,
    output logic [DATA_W-1:0]      fwd_rd1,
    output logic [DATA_W-1:0]      fwd_rd2,
`endif
    output logic                   regWrite,
    output logic [ADDR_W-1:0]      A3,
    output logic [DATA_W-1:0]      WD3,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [CNT_W-1:0]       conflict_cnt
);

    localparam int NREG = 2**ADDR_W;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e              last_grant;
    logic                xfer;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [NREG-1:0]     busy_next;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!rst) begin
            if (alu_valid && (!mem_valid || last_grant == GRANT_MEM))
                alu_ready = 1'b1;
            else if (mem_valid)
                mem_ready = 1'b1;
        end
    end

    assign xfer     = alu_ready || mem_ready;
    assign win_addr = alu_ready ? alu_addr : mem_addr;
    assign win_data = alu_ready ? alu_data : mem_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            regWrite   <= 1'b0;
            A3         <= '0;
            WD3        <= '0;
            last_grant <= GRANT_MEM;
        end else begin
            regWrite <= xfer;
            if (xfer) begin
                A3         <= win_addr;
                WD3        <= win_data;
                last_grant <= alu_ready ? GRANT_ALU : GRANT_MEM;
            end
        end
    end

    // The set is applied after the clear so a new issue keeps ownership of its register.
    always_comb begin
        busy_next = busy;
        if (xfer)
            busy_next[win_addr] = 1'b0;
        if (issue_valid)
            busy_next[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (alu_valid && mem_valid && conflict_cnt != {CNT_W{1'b1}})
            conflict_cnt <= conflict_cnt + CNT_W'(1);
    end

`ifdef WB_FWD_EN
    // Bypass the in-flight write to a read issued before the register file commits it.
    assign fwd_rd1 = (regWrite && A3 == rd_a1) ? WD3 : rf_rd1;
    assign fwd_rd2 = (regWrite && A3 == rd_a2) ? WD3 : rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors plus a cycle-level reference model.
// Build with WB_FWD_EN defined to also exercise the forwarding mux.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 4;
    localparam int NREG   = 16;
    localparam int SAT    = (1 << CNT_W) - 1;

    localparam int W_NONE = 0;
    localparam int W_ALU  = 1;
    localparam int W_MEM  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                alu_valid = 1'b0;
    logic [ADDR_W-1:0]   alu_addr = '0;
    logic [DATA_W-1:0]   alu_data = '0;
    logic                alu_ready;
    logic                mem_valid = 1'b0;
    logic [ADDR_W-1:0]   mem_addr = '0;
    logic [DATA_W-1:0]   mem_data = '0;
    logic                mem_ready;
    logic                issue_valid = 1'b0;
    logic [ADDR_W-1:0]   issue_addr = '0;
    logic                regWrite;
    logic [ADDR_W-1:0]   A3;
    logic [DATA_W-1:0]   WD3;
    logic [NREG-1:0]     busy;
    logic [CNT_W-1:0]    conflict_cnt;
`ifdef WB_FWD_EN
    logic [ADDR_W-1:0]   rd_a1 = '0;
    logic [ADDR_W-1:0]   rd_a2 = '0;
    logic [DATA_W-1:0]   rf_rd1 = '0;
    logic [DATA_W-1:0]   rf_rd2 = '0;
    logic [DATA_W-1:0]   fwd_rd1;
    logic [DATA_W-1:0]   fwd_rd2;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
`ifdef WB_FWD_EN
        .rd_a1        (rd_a1),
        .rd_a2        (rd_a2),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .fwd_rd1      (fwd_rd1),
        .fwd_rd2      (fwd_rd2),
`endif
        .regWrite     (regWrite),
        .A3           (A3),
        .WD3          (WD3),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: who should win now, what the write port should show, which registers are owned.
    bit        m_live = 0;
    int        m_last = W_MEM;
    bit        m_we = 0;
    int        m_a3 = 0;
    int        m_wd = 0;
    bit        m_busy [NREG];
    int        m_conf = 0;

    function automatic int winner();
        if (rst) return W_NONE;
        if (alu_valid && mem_valid) return (m_last == W_ALU) ? W_MEM : W_ALU;
        if (alu_valid) return W_ALU;
        if (mem_valid) return W_MEM;
        return W_NONE;
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_live = 1;
            m_last = W_MEM;
            m_we   = 0;
            m_a3   = 0;
            m_wd   = 0;
            m_conf = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            w = winner();
            if (alu_valid && mem_valid && m_conf < SAT) m_conf++;
            m_we = (w != W_NONE);
            if (w != W_NONE) begin
                m_a3   = (w == W_ALU) ? int'(alu_addr) : int'(mem_addr);
                m_wd   = (w == W_ALU) ? int'(alu_data) : int'(mem_data);
                m_last = w;
                m_busy[m_a3] = 0;
            end
            if (issue_valid) m_busy[issue_addr] = 1;
        end
    end

    always @(negedge clk) begin
        logic [NREG-1:0] exp_busy;
        int w;
        if (m_live) begin
            w = winner();
            foreach (m_busy[i]) exp_busy[i] = m_busy[i];
            check("m_alu_ready", 32'(alu_ready), 32'(w == W_ALU));
            check("m_mem_ready", 32'(mem_ready), 32'(w == W_MEM));
            check("m_regWrite", 32'(regWrite), 32'(m_we));
            check("m_A3", 32'(A3), m_a3);
            check("m_WD3", 32'(WD3), m_wd);
            check("m_busy", 32'(busy), 32'(exp_busy));
            check("m_conflict_cnt", 32'(conflict_cnt), m_conf);
`ifdef WB_FWD_EN
            check("m_fwd_rd1", 32'(fwd_rd1), (m_we && m_a3 == int'(rd_a1)) ? m_wd : int'(rf_rd1));
            check("m_fwd_rd2", 32'(fwd_rd2), (m_we && m_a3 == int'(rd_a2)) ? m_wd : int'(rf_rd2));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with a request pending.
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 16'h5555;
        tick(); tick();
        check("rst_regWrite", 32'(regWrite), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'h0000);
        check("rst_conflict", 32'(conflict_cnt), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        check("rel_WD3", 32'(WD3), 32'h5555);
        alu_valid = 1'b0;

        // Single ALU write to register 0.
        alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 16'h2222;
        tick();
        check("alu_regWrite", 32'(regWrite), 32'd1);
        check("alu_A3", 32'(A3), 32'd0);
        check("alu_WD3", 32'(WD3), 32'h2222);
        alu_valid = 1'b0;
        tick();
        check("idle_regWrite", 32'(regWrite), 32'd0);
        check("idle_WD3_hold", 32'(WD3), 32'h2222);

        // A load alone so MEM becomes last_grant before the tie.
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 16'h7777;
        tick();
        check("mem_A3", 32'(A3), 32'd7);
        mem_valid = 1'b0;

        // Tie to the same register: ALU first, then MEM.
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 16'hFF00;
        mem_valid = 1'b1; mem_addr = 4'd1; mem_data = 16'h1234;
        #1;
        check("tie1_alu_ready", 32'(alu_ready), 32'd1);
        check("tie1_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        check("tie1_WD3", 32'(WD3), 32'hFF00);
        check("tie1_conflict", 32'(conflict_cnt), 32'd1);
        alu_valid = 1'b0;
        #1;
        check("tie2_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        check("tie2_WD3", 32'(WD3), 32'h1234);
        check("tie2_A3", 32'(A3), 32'd1);
        mem_valid = 1'b0;

        // Second tie: ALU wins again because MEM went last.
        alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'hAAAA;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 16'hBBBB;
        tick();
        check("tie3_WD3", 32'(WD3), 32'hAAAA);
        check("tie3_conflict", 32'(conflict_cnt), 32'd2);
        alu_valid = 1'b0;
        tick();
        check("tie4_WD3", 32'(WD3), 32'hBBBB);

        // Sustained contention drives the counter into saturation.
        alu_valid = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check("sat_conflict", 32'(conflict_cnt), SAT);
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        // Scoreboard: set, set-wins-over-clear, then clear.
        issue_valid = 1'b1; issue_addr = 4'd3;
        tick();
        check("sb_set", 32'(busy), 32'h0008);
        mem_valid = 1'b1; mem_addr = 4'd3; mem_data = 16'h3333;
        tick();
        check("sb_set_wins", 32'(busy), 32'h0008);
        issue_valid = 1'b0; mem_data = 16'h3334;
        tick();
        check("sb_clear", 32'(busy), 32'h0000);
        mem_valid = 1'b0;

        // Reset in the middle of a write.
        alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 16'h9999;
        issue_valid = 1'b1; issue_addr = 4'd4;
        tick();
        check("mid_regWrite", 32'(regWrite), 32'd1);
        check("mid_busy", 32'(busy), 32'h0010);
        alu_valid = 1'b0; issue_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 4'd6; mem_data = 16'h6666;
        rst = 1'b1;
        #1;
        check("mid_mem_ready_rst", 32'(mem_ready), 32'd0);
        tick();
        check("mid_squash", 32'(regWrite), 32'd0);
        check("mid_busy_clr", 32'(busy), 32'h0000);
        mem_valid = 1'b0;
        rst = 1'b0;
        tick();

`ifdef WB_FWD_EN
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 16'hFF00;
        tick();
        alu_valid = 1'b0;
        rd_a1 = 4'd1; rf_rd1 = 16'h0000;
        rd_a2 = 4'd0; rf_rd2 = 16'h2222;
        #1;
        check("fwd_rd1", 32'(fwd_rd1), 32'hFF00);
        check("fwd_rd2", 32'(fwd_rd2), 32'h2222);
        tick();
        check("fwd_rd1_idle", 32'(fwd_rd1), 32'h0000);
`endif

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port (regWrite/A3/WD3) of the 16x16 register file between two writeback requesters: ALU and memory-load.
- Round-robin arbitration with valid/ready handshakes and a registered write stage.
- Keeps a per-register busy scoreboard, set at issue and cleared at writeback, for the hazard/stall logic.
- Sits between the execute/memory stages and register_file.

Parameters:
DATA_W, 16, data width of the register file write port
ADDR_W, 4, register address width; NREG = 2**ADDR_W registers
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle (combinational)
mem_valid  in  1  memory-load writeback request
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load request accepted this cycle (combinational)
issue_valid  in  1  instruction issued that will write issue_addr
issue_addr  in  ADDR_W  destination of the issued instruction
regWrite  out  1  register file write enable (registered)
A3  out  ADDR_W  register file write address (registered)
WD3  out  DATA_W  register file write data (registered)
busy  out  NREG  scoreboard; bit i = register i has a pending write
conflict_cnt  out  CNT_W  saturating count of cycles with both requesters valid

Behaviour:
- Reset, synchronous on rising clk with rst=1:
  - regWrite=0, A3=0, WD3=0, busy=0, conflict_cnt=0.
  - last_grant=MEM, so ALU wins the first tie.
  - All requests are ignored while rst=1; alu_ready=mem_ready=0 while rst=1.
- Grant, combinational from the current inputs and last_grant:
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the requester that is not last_grant.
  - Neither valid: no grant.
  - ready = grant. A transfer happens when valid && ready.
  - At most one transfer per cycle.
- Requester rules:
  - addr and data must be held stable while valid=1 and ready=0.
  - valid must not drop before acceptance.
  - A violation is a requester bug; it is not checked.
- Write stage:
  - On a transfer at edge N: regWrite=1, A3=granted addr, WD3=granted data, all valid from edge N to N+1. The register file commits at edge N+1.
  - No transfer: regWrite=0; A3/WD3 hold their previous values.
  - last_grant updates only on a transfer.
  - Latency from acceptance to register file commit is 2 edges.
- Busy scoreboard, evaluated at each edge:
  - set: issue_valid sets busy[issue_addr].
  - clear: a transfer clears busy[granted addr] at the same edge the write stage loads.
  - Set and clear of the same register in the same cycle: set wins. The new instruction still owns the register.
  - Clearing an already-clear bit is a no-op.
  - Register 0 is an ordinary writable register with no special case.
- Same destination from ALU and MEM in the same cycle: both writes happen in grant order over 2 cycles. The later write's value remains in the register.
- conflict_cnt:
  - Increments each cycle alu_valid && mem_valid with rst=0.
  - Saturates at 2**CNT_W-1, with no wrap.
- Reset asserted mid-operation:
  - Pending, unaccepted requests are dropped.
  - A write already in the write stage is squashed: regWrite=0 from the reset edge.
  - Busy bits are cleared.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - Adds inputs rd_a1, rd_a2 (ADDR_W) and rf_rd1, rf_rd2 (DATA_W).
  - Adds outputs fwd_rd1, fwd_rd2 (DATA_W).
  - Combinational: fwd_rdX = WD3 when regWrite && A3==rd_aX, otherwise rf_rdX.
  - This covers a read issued in the same cycle as the in-flight write.
- Undefined: these ports and the mux do not exist; consumers read register_file directly.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with alu_valid=1 -> regWrite=0, alu_ready=0, busy=16'h0000, conflict_cnt=0. Release -> alu_ready=1 in the next cycle.
2. Single ALU write: alu_valid=1, alu_addr=0, alu_data=16'h2222 for 1 cycle -> next cycle regWrite=1, A3=0, WD3=16'h2222. Following cycle regWrite=0.
3. Tie and round-robin:
   - Both valid: ALU (addr 1, 16'hFF00) and MEM (addr 1, 16'h1234) -> cycle 1 grants ALU, cycle 2 grants MEM.
   - Writes on consecutive cycles are 16'hFF00 then 16'h1234.
   - conflict_cnt=1.
   - A second tie afterwards grants ALU first again, since last_grant=MEM.
4. Scoreboard: issue_valid with issue_addr=3 -> busy=16'h0008. Then MEM write to addr 3 with a simultaneous issue_valid to addr 3 -> busy stays 16'h0008 (set wins). A later MEM write to 3 with no issue -> busy=16'h0000.
5. Reset mid-operation: ALU accepted at edge N, rst=1 at edge N+1 -> regWrite=0 after edge N+1 and busy cleared.
6. WB_FWD_EN:
   - regWrite=1, A3=1, WD3=16'hFF00, rd_a1=1, rf_rd1=16'h0000 -> fwd_rd1=16'hFF00.
   - rd_a2=0, rf_rd2=16'h2222 -> fwd_rd2=16'h2222.
